// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multicycle signed multiply/divide unit with HI/LO result
//                registers. MULT uses radix-2 Booth recoding, DIV uses
//                restoring division on operand magnitudes with a final
//                sign-fix cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;

    // Booth accumulator: {partial product (W+1 bits), multiplier (W bits), q-1}.
    // The partial-product field carries one guard bit so that subtracting
    // the most negative multiplicand cannot overflow before the shift.
    logic [2*WIDTH+1:0] acc;
    logic [2*WIDTH+1:0] acc_next;
    logic [WIDTH:0]     pp_sum;

    // Operand B: multiplicand for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0]   opb;

    // Restoring divider state: partial remainder and quotient/dividend shifter.
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    logic               sign_a;
    logic               sign_b;
    logic [CW-1:0]      count;

    // One Booth step: add/subtract the multiplicand, then arithmetic shift.
    always_comb begin
        pp_sum = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   pp_sum = acc[2*WIDTH+1:WIDTH+1] + {opb[WIDTH-1], opb};
            2'b10:   pp_sum = acc[2*WIDTH+1:WIDTH+1] - {opb[WIDTH-1], opb};
            default: pp_sum = acc[2*WIDTH+1:WIDTH+1];
        endcase
        acc_next = {pp_sum[WIDTH], pp_sum, acc[WIDTH:1]};
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor if it fits. The shifted remainder is always below
    // 2^WIDTH, so bit WIDTH of the difference is a valid borrow flag.
    always_comb begin
        div_shift = {rem, quot[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (div_diff[WIDTH]) begin
            rem_next = div_shift[WIDTH-1:0];
        end else begin
            rem_next = div_diff[WIDTH-1:0];
        end
        quot_next = {quot[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    // Control FSM with registered busy/done/div_zero and HI/LO updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opb      <= '0;
            rem      <= '0;
            quot     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            count    <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mult) begin
                        acc   <= {{(WIDTH+1){1'b0}}, a, 1'b0};
                        opb   <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_MULT;
                    end else if (start_div) begin
                        busy <= 1'b1;
                        if (b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            sign_a <= a[WIDTH-1];
                            sign_b <= b[WIDTH-1];
                            quot   <= a[WIDTH-1] ? -a : a;
                            opb    <= b[WIDTH-1] ? -b : b;
                            rem    <= '0;
                            count  <= '0;
                            state  <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc   <= acc_next;
                    count <= count + ONE;
                    if (count == LAST) begin
                        hi    <= acc_next[2*WIDTH:WIDTH+1];
                        lo    <= acc_next[WIDTH:1];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quot  <= quot_next;
                    count <= count + ONE;
                    if (count == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo    <= (sign_a ^ sign_b) ? -quot : quot;
                    hi    <= sign_a ? -rem : rem;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit: directed vector table,
//                hand-written corner sequences, and randomized operations
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural HI/LO plus expected flags.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_dz;
    int          m_lat;

    typedef struct {
        bit          is_div;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          exp_dz;
    } vec_t;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level model: plain signed arithmetic in 64 bits.
    task automatic model(input bit is_div, input logic [31:0] ta, input logic [31:0] tb);
        longint sa, sb, p, q, r;
        sa   = longint'($signed(ta));
        sb   = longint'($signed(tb));
        m_dz = 1'b0;
        if (!is_div) begin
            p     = sa * sb;
            m_hi  = p[63:32];
            m_lo  = p[31:0];
            m_lat = 33;
        end else if (tb == 32'd0) begin
            m_dz  = 1'b1;
            m_lat = 1;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            m_hi  = r[31:0];
            m_lo  = q[31:0];
            m_lat = 34;
        end
    endtask

    // Issue one operation and wait (bounded) for done. Cycle 1 is the cycle
    // after the start edge; lat=0 means done never arrived.
    task automatic run_op(input bit is_div, input logic [31:0] ta, input logic [31:0] tb,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        a          = ta;
        b          = tb;
        start_mult = !is_div;
        start_div  = is_div;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        lat        = 0;
        busy_ok    = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done_after"}, {63'd0, done}, 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int  lat;
        bit  bok;
        int  pulses;

        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = '0;
        b          = '0;

        vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6] = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b0};
        vecs[7] = '{1'b1, 32'd5,        32'd0,        32'h00000000, 32'h0000000F, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz",   {63'd0, div_zero}, 64'd0);
        chk("rst_hi",   {32'd0, hi}, 64'd0);
        chk("rst_lo",   {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            int exp_lat;
            exp_lat = !vecs[i].is_div ? 33 : (vecs[i].vb == 32'd0 ? 1 : 34);
            run_op(vecs[i].is_div, vecs[i].va, vecs[i].vb, lat, bok);
            chk($sformatf("vec%0d_lat", i),  64'(lat), 64'(exp_lat));
            chk($sformatf("vec%0d_busy", i), {63'd0, bok}, 64'd1);
            chk($sformatf("vec%0d_hi", i),   {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk($sformatf("vec%0d_lo", i),   {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            chk($sformatf("vec%0d_dz", i),   {63'd0, div_zero}, {63'd0, vecs[i].exp_dz});
            model(vecs[i].is_div, vecs[i].va, vecs[i].vb);
            finish_op($sformatf("vec%0d", i));
        end

        // Both starts high: multiply wins; a start at cycle 10 and one during
        // the DONE cycle are both ignored.
        @(negedge clk);
        a          = 32'd6;
        b          = 32'd4;
        start_mult = 1'b1;
        start_div  = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        lat        = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                start_div = 1'b1;
                b         = 32'd3;
            end
            if (c == 11) start_div = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("both_lat", 64'(lat), 64'd33);
        chk("both_lo",  {32'd0, lo}, 64'd24);
        chk("both_hi",  {32'd0, hi}, 64'd0);
        chk("both_dz",  {63'd0, div_zero}, 64'd0);
        model(1'b0, 32'd6, 32'd4);
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        chk("both_busy_after", {63'd0, busy}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) pulses++;
            @(posedge clk);
            #1;
        end
        chk("both_no_queued", 64'(pulses), 64'd0);

        // Reset mid-divide aborts immediately, then a clean rerun.
        @(negedge clk);
        a         = 32'd100;
        b         = 32'd7;
        start_div = 1'b1;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi",   {32'd0, hi}, 64'd0);
        chk("abort_lo",   {32'd0, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b1, 32'd100, 32'd7, lat, bok);
        chk("rerun_lat", 64'(lat), 64'd34);
        chk("rerun_lo",  {32'd0, lo}, 64'd14);
        chk("rerun_hi",  {32'd0, hi}, 64'd2);
        model(1'b1, 32'd100, 32'd7);
        finish_op("rerun");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit          op;
            logic [31:0] ra, rb;
            op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       ra = 32'($urandom_range(0, 50)) - 32'd25;
                1:       ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            model(op, ra, rb);
            run_op(op, ra, rb, lat, bok);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(m_lat));
            chk($sformatf("rnd%0d_busy", i), {63'd0, bok}, 64'd1);
            chk($sformatf("rnd%0d_hi", i), {32'd0, hi}, {32'd0, m_hi});
            chk($sformatf("rnd%0d_lo", i), {32'd0, lo}, {32'd0, m_lo});
            chk($sformatf("rnd%0d_dz", i), {63'd0, div_zero}, {63'd0, m_dz});
            finish_op($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
